// File: rtl/axi4_lite_reg_pkg.sv
// axi4_lite_reg_pkg: shared FSM state types, response codes and byte-lane merge for the AXI4-Lite register slave
package axi4_lite_reg_pkg;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // Works on up to 64-bit words; callers zero-extend and truncate to their own width
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v, input logic [7:0] strb);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite channel bundle with responder (s) and requester (m) views
interface axi4_lite_if #(parameter int DW = 32, parameter int AW = 32);
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    modport s (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport m (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_reg_wr_ctrl.sv
// axi4_lite_reg_wr_ctrl: AW/W capture in either order and B response FSM; emits a commit strobe with idx/data/strb
// AXI4_LITE_REG_SLAVE_ERR_EN: writes to RO or out-of-range indices answer SLVERR
module axi4_lite_reg_wr_ctrl
    import axi4_lite_reg_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32,
    parameter int IDXW  = 5
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            awvalid,
    output logic            awready,
    input  logic [IDXW-1:0] aw_idx,
    input  logic            wvalid,
    output logic            wready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic            commit,
    output logic [IDXW-1:0] idx,
    output logic [DW-1:0]   data,
    output logic [DW/8-1:0] strb
);
    wr_state_t state, state_n;
    logic rdy, aw_held, w_held, aw_hs, w_hs;
    logic [IDXW-1:0] idx_q;
    logic [DW-1:0] data_q;
    logic [DW/8-1:0] strb_q;
    logic [1:0] resp_n;
    always_comb begin
        awready = rdy && state == W_IDLE && !aw_held;
        wready  = rdy && state == W_IDLE && !w_held;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        commit  = state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
        idx     = aw_held ? idx_q : aw_idx;
        data    = w_held ? data_q : wdata;
        strb    = w_held ? strb_q : wstrb;
        bvalid  = state == W_RESP;
        resp_n  = RESP_OKAY;
`ifdef AXI4_LITE_REG_SLAVE_ERR_EN
        resp_n  = 32'(idx) >= NREGS ? RESP_SLVERR : RESP_OKAY;
`endif
        state_n = commit ? W_RESP : (state == W_RESP && bready) ? W_IDLE : state;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= W_IDLE;
            rdy     <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            state   <= state_n;
            rdy     <= 1'b1;
            aw_held <= !commit && (aw_held || aw_hs);
            w_held  <= !commit && (w_held || w_hs);
            if (aw_hs) idx_q <= aw_idx;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (commit) bresp <= resp_n;
        end
    end
endmodule

// File: rtl/axi4_lite_reg_slave.sv
// axi4_lite_reg_slave: AXI4-Lite responder exposing NREGS RW control and NRO RO status registers
// AXI4_LITE_REG_SLAVE_ERR_EN: out-of-range accesses and RO writes answer SLVERR instead of OKAY
module axi4_lite_reg_slave
    import axi4_lite_reg_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int NRO   = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi4_lite_if.s                    axi,
    output logic [NREGS-1:0][DW-1:0]  ctrl_o,
    output logic [NREGS-1:0]          ctrl_wr_o,
    input  logic [NRO-1:0][DW-1:0]    stat_i,
    output logic [NRO-1:0]            stat_rd_o
);
    localparam int LSB  = $clog2(DW/8);
    localparam int IDXW = $clog2(NREGS + NRO);
    rd_state_t rstate, rstate_n;
    logic rdy, ar_hs, commit, unused_addr;
    logic [AW-1:0] awaddr, araddr;
    logic [IDXW-1:0] ridx, wr_idx;
    logic [DW-1:0] rd_val, rdata, wr_data;
    logic [DW/8-1:0] wr_strb;
    logic [1:0] rd_resp, rresp;
    assign awaddr      = axi.awaddr;
    assign araddr      = axi.araddr;
    assign unused_addr = ^{awaddr, araddr};
    assign ridx        = araddr[LSB +: IDXW];
    assign axi.arready = rdy && rstate == R_IDLE;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign axi.rvalid  = rstate == R_RESP;
    assign axi.rdata   = rdata;
    assign axi.rresp   = rresp;
    axi4_lite_reg_wr_ctrl #(.NREGS(NREGS), .DW(DW), .IDXW(IDXW)) u_wr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (axi.awvalid),
        .awready (axi.awready),
        .aw_idx  (awaddr[LSB +: IDXW]),
        .wvalid  (axi.wvalid),
        .wready  (axi.wready),
        .wdata   (axi.wdata),
        .wstrb   (axi.wstrb),
        .bvalid  (axi.bvalid),
        .bready  (axi.bready),
        .bresp   (axi.bresp),
        .commit  (commit),
        .idx     (wr_idx),
        .data    (wr_data),
        .strb    (wr_strb)
    );
    // Unmatched indices fall through to zero, which covers out-of-range reads
    always_comb begin
        rd_val    = '0;
        ctrl_wr_o = '0;
        stat_rd_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            rd_val       = ridx == IDXW'(i) ? ctrl_o[i] : rd_val;
            ctrl_wr_o[i] = commit && wr_idx == IDXW'(i);
        end
        for (int j = 0; j < NRO; j++) begin
            rd_val       = ridx == IDXW'(NREGS + j) ? stat_i[j] : rd_val;
            stat_rd_o[j] = ar_hs && ridx == IDXW'(NREGS + j);
        end
        rd_resp = RESP_OKAY;
`ifdef AXI4_LITE_REG_SLAVE_ERR_EN
        rd_resp = 32'(ridx) >= NREGS + NRO ? RESP_SLVERR : RESP_OKAY;
`endif
        rstate_n = ar_hs ? R_RESP : (rstate == R_RESP && axi.rready) ? R_IDLE : rstate;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy    <= 1'b0;
            rstate <= R_IDLE;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            ctrl_o <= '0;
        end else begin
            rdy    <= 1'b1;
            rstate <= rstate_n;
            if (ar_hs) begin
                rdata <= rd_val;
                rresp <= rd_resp;
            end
            for (int i = 0; i < NREGS; i++)
                if (commit && wr_idx == IDXW'(i))
                    ctrl_o[i] <= DW'(strb_merge(64'(ctrl_o[i]), 64'(wr_data), 8'(wr_strb)));
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb_axi4_lite_reg_slave: directed bench for axi4_lite_reg_slave; honours AXI4_LITE_REG_SLAVE_ERR_EN for error responses
module tb_axi4_lite_reg_slave;
    localparam int NREGS = 16;
    localparam int NRO   = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
`ifdef AXI4_LITE_REG_SLAVE_ERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [NREGS-1:0][DW-1:0] ctrl_o, exp_ctrl;
    logic [NREGS-1:0] ctrl_wr_o;
    logic [NRO-1:0][DW-1:0] stat_i;
    logic [NRO-1:0] stat_rd_o;
    int vecs = 0;
    int errs = 0;
    axi4_lite_if #(.DW(DW), .AW(AW)) bus();
    axi4_lite_reg_slave #(.NREGS(NREGS), .NRO(NRO), .DW(DW), .AW(AW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .axi       (bus),
        .ctrl_o    (ctrl_o),
        .ctrl_wr_o (ctrl_wr_o),
        .stat_i    (stat_i),
        .stat_rd_o (stat_rd_o)
    );
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic mid();
        @(negedge aclk);
    endtask
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic aw(input int idx);
        bus.awvalid = 1'b1;
        bus.awaddr  = AW'(idx * 4);
    endtask
    task automatic w(input logic [31:0] d, input logic [3:0] s);
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        bus.wstrb  = s;
    endtask
    task automatic ar(input int idx);
        bus.arvalid = 1'b1;
        bus.araddr  = AW'(idx * 4);
    endtask
    task automatic idle();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        stat_i = '0;
        stat_i[1] = 32'hCAFE_0001;
        stat_i[2] = 32'h0BAD_F00D;
        exp_ctrl = '0;
        // reset state
        repeat (2) step();
        mid();
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_ctrl", ctrl_o, exp_ctrl);
        chk("rst_ctrl_wr", ctrl_wr_o, 0);
        step();
        aresetn = 1'b1;
        // 1: AW and W together to idx 3
        step();
        aw(3);
        w(32'hA5A5_1234, 4'hF);
        mid();
        chk("t1_awready", bus.awready, 1);
        chk("t1_wready", bus.wready, 1);
        chk("t1_arready", bus.arready, 1);
        chk("t1_ctrl_wr", ctrl_wr_o, 16'h0008);
        chk("t1_bvalid_early", bus.bvalid, 0);
        step();
        idle();
        mid();
        exp_ctrl[3] = 32'hA5A5_1234;
        chk("t1_bvalid", bus.bvalid, 1);
        chk("t1_bresp", bus.bresp, 2'b00);
        chk("t1_ctrl", ctrl_o, exp_ctrl);
        chk("t1_ctrl_wr_once", ctrl_wr_o, 0);
        chk("t1_awready_resp", bus.awready, 0);
        bus.bready = 1;
        step();
        bus.bready = 0;
        mid();
        chk("t1_bdone", bus.bvalid, 0);
        chk("t1_awready_back", bus.awready, 1);
        // 2: W five cycles ahead of AW, partial strobe
        step();
        w(32'h0000_7700, 4'b0010);
        step();
        bus.wvalid = 0;
        mid();
        chk("t2_wready_held", bus.wready, 0);
        chk("t2_bvalid_wait", bus.bvalid, 0);
        repeat (4) step();
        aw(3);
        mid();
        chk("t2_bvalid_pre_aw", bus.bvalid, 0);
        chk("t2_ctrl_wr", ctrl_wr_o, 16'h0008);
        step();
        idle();
        mid();
        exp_ctrl[3] = 32'hA5A5_7734;
        chk("t2_ctrl", ctrl_o, exp_ctrl);
        chk("t2_bvalid", bus.bvalid, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            mid();
            chk("t2_bvalid_hold", bus.bvalid, 1);
            chk("t2_bresp_hold", bus.bresp, 2'b00);
        end
        bus.bready = 1;
        step();
        bus.bready = 0;
        mid();
        chk("t2_bdone", bus.bvalid, 0);
        // 3: status read with rready stalled
        step();
        ar(NREGS + 1);
        mid();
        chk("t3_arready", bus.arready, 1);
        chk("t3_stat_rd", stat_rd_o, 4'b0010);
        step();
        idle();
        stat_i[1] = 32'h1111_1111;
        mid();
        chk("t3_rvalid", bus.rvalid, 1);
        chk("t3_rdata", bus.rdata, 32'hCAFE_0001);
        chk("t3_rresp", bus.rresp, 2'b00);
        chk("t3_stat_rd_once", stat_rd_o, 0);
        chk("t3_arready_busy", bus.arready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            mid();
            chk("t3_rvalid_hold", bus.rvalid, 1);
            chk("t3_rdata_hold", bus.rdata, 32'hCAFE_0001);
        end
        bus.rready = 1;
        step();
        bus.rready = 0;
        mid();
        chk("t3_rdone", bus.rvalid, 0);
        // 4: out-of-range read and write to an RO index
        step();
        ar(25);
        mid();
        chk("t4_stat_rd", stat_rd_o, 0);
        step();
        idle();
        mid();
        chk("t4_rvalid", bus.rvalid, 1);
        chk("t4_rresp", bus.rresp, ERR);
        chk("t4_rdata", bus.rdata, 0);
        bus.rready = 1;
        step();
        bus.rready = 0;
        aw(17);
        w(32'hFFFF_FFFF, 4'hF);
        mid();
        chk("t4_ctrl_wr", ctrl_wr_o, 0);
        step();
        idle();
        mid();
        chk("t4_bvalid", bus.bvalid, 1);
        chk("t4_bresp", bus.bresp, ERR);
        chk("t4_ctrl", ctrl_o, exp_ctrl);
        bus.bready = 1;
        step();
        bus.bready = 0;
        // 5: same-cycle read and write of idx 0
        aw(0);
        w(32'h0000_0001, 4'hF);
        step();
        idle();
        bus.bready = 1;
        step();
        bus.bready = 0;
        exp_ctrl[0] = 32'h1;
        aw(0);
        w(32'h0000_0002, 4'hF);
        ar(0);
        step();
        idle();
        mid();
        exp_ctrl[0] = 32'h2;
        chk("t5_rdata_old", bus.rdata, 32'h1);
        chk("t5_ctrl", ctrl_o, exp_ctrl);
        chk("t5_bvalid", bus.bvalid, 1);
        chk("t5_rvalid", bus.rvalid, 1);
        bus.bready = 1;
        bus.rready = 1;
        step();
        bus.bready = 0;
        bus.rready = 0;
        ar(0);
        step();
        idle();
        mid();
        chk("t5_rdata_new", bus.rdata, 32'h2);
        bus.rready = 1;
        step();
        bus.rready = 0;
        // 6: reset while B is pending
        aw(5);
        w(32'h0000_0055, 4'hF);
        step();
        idle();
        mid();
        chk("t6_bvalid_pend", bus.bvalid, 1);
        aresetn = 1'b0;
        #1;
        exp_ctrl = '0;
        chk("t6_bvalid_drop", bus.bvalid, 0);
        chk("t6_ctrl_clr", ctrl_o, exp_ctrl);
        chk("t6_awready_drop", bus.awready, 0);
        chk("t6_arready_drop", bus.arready, 0);
        step();
        aresetn = 1'b1;
        step();
        step();
        mid();
        chk("t6_no_owed_b", bus.bvalid, 0);
        chk("t6_awready_back", bus.awready, 1);
        aw(5);
        w(32'h1234_5678, 4'hF);
        step();
        idle();
        mid();
        exp_ctrl[5] = 32'h1234_5678;
        chk("t6_bvalid", bus.bvalid, 1);
        chk("t6_bresp", bus.bresp, 2'b00);
        chk("t6_ctrl", ctrl_o, exp_ctrl);
        bus.bready = 1;
        step();
        bus.bready = 0;
        mid();
        chk("t6_bdone", bus.bvalid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
